// File: rtl/branch_slot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_slot_ctrl
// Brief    : Tracks branch/jump instructions crossing ID->EX and tags the next
//            real instruction entering EX as a delay-slot instruction, even
//            across bubbles and stalls. Supplies EPC/BD values for CP0.
// Revision : 1.0 - initial release
// ============================================================================
module branch_slot_ctrl #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid_i,
    input  logic [PC_W-1:0] id_pc_i,
    input  logic            id_is_jmp_i,
    input  logic            id_is_jr_i,
    input  logic            id_is_branch_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            ex_valid_o,
    output logic [PC_W-1:0] ex_pc_o,
    output logic            ex_in_delay_slot_o,
    output logic [PC_W-1:0] ex_branch_pc_o,
    output logic [PC_W-1:0] ex_epc_o,
    output logic            ex_bd_o,
    output logic            nested_err_o
);

    // NORM: nothing pending; WAIT_SLOT: branch seen, slot not yet in EX;
    // SLOT: EX currently holds the slot instruction.
    typedef enum logic [1:0] {
        NORM      = 2'd0,
        WAIT_SLOT = 2'd1,
        SLOT      = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            ex_valid_q, ex_valid_d;
    logic [PC_W-1:0] ex_pc_q, ex_pc_d;
    logic            ex_ds_q, ex_ds_d;
    logic [PC_W-1:0] ex_bpc_q, ex_bpc_d;
    logic [PC_W-1:0] br_pc_q, br_pc_d;
    logic            nested_q, nested_d;

    logic            w_id_ctl;

    assign w_id_ctl = id_is_jmp_i | id_is_jr_i | id_is_branch_i;

    // State and EX-stage registers; reset takes effect without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= NORM;
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_ds_q    <= 1'b0;
            ex_bpc_q   <= '0;
            br_pc_q    <= '0;
            nested_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_ds_q    <= ex_ds_d;
            ex_bpc_q   <= ex_bpc_d;
            br_pc_q    <= br_pc_d;
            nested_q   <= nested_d;
        end
    end

    // Next-state logic: flush beats stall, stall holds everything, then bubble/advance.
    always_comb begin
        state_d    = state_q;
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_ds_d    = ex_ds_q;
        ex_bpc_d   = ex_bpc_q;
        br_pc_d    = br_pc_q;
        nested_d   = nested_q;

        if (flush_i) begin
            // Cancels any pending slot; the sticky error survives a flush.
            state_d    = NORM;
            ex_valid_d = 1'b0;
            ex_ds_d    = 1'b0;
            ex_bpc_d   = '0;
            br_pc_d    = '0;
        end else if (stall_i) begin
            state_d = state_q;
        end else if (!id_valid_i) begin
            // Bubble: a pending slot (WAIT_SLOT) must survive, only SLOT retires.
            ex_valid_d = 1'b0;
            ex_ds_d    = 1'b0;
            ex_bpc_d   = '0;
            if (state_q == SLOT) begin
                state_d = NORM;
            end
        end else begin
            ex_valid_d = 1'b1;
            ex_pc_d    = id_pc_i;
            if (state_q == WAIT_SLOT) begin
                // Slot instruction arrives; a control transfer here is illegal
                // and is not allowed to open another slot.
                ex_ds_d  = 1'b1;
                ex_bpc_d = br_pc_q;
                state_d  = SLOT;
                if (w_id_ctl) begin
                    nested_d = 1'b1;
                end
            end else begin
                ex_ds_d  = 1'b0;
                ex_bpc_d = '0;
                if (w_id_ctl) begin
                    state_d = WAIT_SLOT;
                    br_pc_d = id_pc_i;
                end else begin
                    state_d = NORM;
                end
            end
        end
    end

    assign ex_valid_o         = ex_valid_q;
    assign ex_pc_o            = ex_pc_q;
    assign ex_in_delay_slot_o = ex_ds_q;
    assign ex_branch_pc_o     = ex_bpc_q;
    assign ex_epc_o           = ex_ds_q ? ex_bpc_q : ex_pc_q;
    assign ex_bd_o            = ex_ds_q;
    assign nested_err_o       = nested_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_slot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_slot_ctrl
// Brief    : Directed self-checking bench for branch_slot_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_slot_ctrl;

    localparam int PC_W = 32;

    logic            clk;
    logic            rst;
    logic            id_valid;
    logic [PC_W-1:0] id_pc;
    logic            id_is_jmp;
    logic            id_is_jr;
    logic            id_is_branch;
    logic            stall;
    logic            flush;
    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic            ex_ds;
    logic [PC_W-1:0] ex_bpc;
    logic [PC_W-1:0] ex_epc;
    logic            ex_bd;
    logic            nested_err;

    int tests;
    int fails;

    branch_slot_ctrl #(.PC_W(PC_W)) u_dut (
        .clk                (clk),
        .rst                (rst),
        .id_valid_i         (id_valid),
        .id_pc_i            (id_pc),
        .id_is_jmp_i        (id_is_jmp),
        .id_is_jr_i         (id_is_jr),
        .id_is_branch_i     (id_is_branch),
        .stall_i            (stall),
        .flush_i            (flush),
        .ex_valid_o         (ex_valid),
        .ex_pc_o            (ex_pc),
        .ex_in_delay_slot_o (ex_ds),
        .ex_branch_pc_o     (ex_bpc),
        .ex_epc_o           (ex_epc),
        .ex_bd_o            (ex_bd),
        .nested_err_o       (nested_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of ID inputs, then sample 1 time unit after the edge.
    task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic j,
                         input logic jr, input logic br, input logic st, input logic fl);
        id_valid     = v;
        id_pc        = pc;
        id_is_jmp    = j;
        id_is_jr     = jr;
        id_is_branch = br;
        stall        = st;
        flush        = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", ex_valid); end
        tests++; if (ex_pc !== '0) begin fails++; $display("FAIL reset_pc got=%h exp=0", ex_pc); end
        tests++; if (ex_ds !== 1'b0) begin fails++; $display("FAIL reset_ds got=%0b exp=0", ex_ds); end
        tests++; if (ex_epc !== '0) begin fails++; $display("FAIL reset_epc got=%h exp=0", ex_epc); end
        tests++; if (nested_err !== 1'b0) begin fails++; $display("FAIL reset_nested got=%0b exp=0", nested_err); end
    endtask

    task automatic test_basic_slot();
        drive(1, 32'h100, 0, 0, 1, 0, 0);
        tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h100) begin fails++; $display("FAIL basic_branch got v=%0b pc=%h exp v=1 pc=100", ex_valid, ex_pc); end
        tests++; if (ex_ds !== 1'b0 || ex_epc !== 32'h100) begin fails++; $display("FAIL basic_branch_ds got ds=%0b epc=%h exp ds=0 epc=100", ex_ds, ex_epc); end
        drive(1, 32'h104, 0, 0, 0, 0, 0);
        tests++; if (ex_ds !== 1'b1 || ex_bd !== 1'b1) begin fails++; $display("FAIL basic_slot_ds got ds=%0b bd=%0b exp 1/1", ex_ds, ex_bd); end
        tests++; if (ex_bpc !== 32'h100 || ex_epc !== 32'h100 || ex_pc !== 32'h104) begin fails++; $display("FAIL basic_slot_pc got bpc=%h epc=%h pc=%h exp 100/100/104", ex_bpc, ex_epc, ex_pc); end
        drive(1, 32'h200, 0, 0, 0, 0, 0);
        tests++; if (ex_ds !== 1'b0 || ex_bpc !== '0 || ex_epc !== 32'h200) begin fails++; $display("FAIL basic_after got ds=%0b bpc=%h epc=%h exp 0/0/200", ex_ds, ex_bpc, ex_epc); end
    endtask

    task automatic test_bubbles_stalls();
        drive(1, 32'h40, 0, 1, 0, 0, 0);
        tests++; if (ex_pc !== 32'h40 || ex_ds !== 1'b0) begin fails++; $display("FAIL jr_enter got pc=%h ds=%0b exp 40/0", ex_pc, ex_ds); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0, 0, 0, 0, 0, 0);
            tests++; if (ex_valid !== 1'b0 || ex_ds !== 1'b0) begin fails++; $display("FAIL bubble%0d got v=%0b ds=%0b exp 0/0", i, ex_valid, ex_ds); end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h44, 0, 0, 0, 1, 0);
            tests++; if (ex_valid !== 1'b0 || ex_pc !== 32'h40 || ex_ds !== 1'b0) begin fails++; $display("FAIL stall%0d got v=%0b pc=%h ds=%0b exp 0/40/0", i, ex_valid, ex_pc, ex_ds); end
        end
        drive(1, 32'h44, 0, 0, 0, 0, 0);
        tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h44 || ex_ds !== 1'b1) begin fails++; $display("FAIL late_slot got v=%0b pc=%h ds=%0b exp 1/44/1", ex_valid, ex_pc, ex_ds); end
        tests++; if (ex_bpc !== 32'h40 || ex_epc !== 32'h40) begin fails++; $display("FAIL late_slot_bpc got bpc=%h epc=%h exp 40/40", ex_bpc, ex_epc); end
        drive(1, 32'h48, 0, 0, 0, 0, 0);
        tests++; if (ex_ds !== 1'b0 || ex_epc !== 32'h48) begin fails++; $display("FAIL post_slot got ds=%0b epc=%h exp 0/48", ex_ds, ex_epc); end
    endtask

    task automatic test_flush_cancel();
        drive(1, 32'h80, 0, 0, 1, 0, 0);
        drive(1, 32'h84, 0, 0, 0, 1, 1);
        tests++; if (ex_valid !== 1'b0 || ex_ds !== 1'b0 || ex_bpc !== '0) begin fails++; $display("FAIL flush got v=%0b ds=%0b bpc=%h exp 0/0/0", ex_valid, ex_ds, ex_bpc); end
        drive(1, 32'h180, 0, 0, 0, 0, 0);
        tests++; if (ex_valid !== 1'b1 || ex_ds !== 1'b0 || ex_epc !== 32'h180) begin fails++; $display("FAIL flush_next got v=%0b ds=%0b epc=%h exp 1/0/180", ex_valid, ex_ds, ex_epc); end
    endtask

    task automatic test_nested();
        drive(1, 32'h10, 1, 0, 0, 0, 0);
        tests++; if (ex_ds !== 1'b0 || nested_err !== 1'b0) begin fails++; $display("FAIL nest_j got ds=%0b err=%0b exp 0/0", ex_ds, nested_err); end
        drive(1, 32'h14, 0, 0, 1, 0, 0);
        tests++; if (ex_ds !== 1'b1 || ex_bpc !== 32'h10 || nested_err !== 1'b1) begin fails++; $display("FAIL nest_beq got ds=%0b bpc=%h err=%0b exp 1/10/1", ex_ds, ex_bpc, nested_err); end
        drive(1, 32'h18, 0, 0, 0, 0, 0);
        tests++; if (ex_ds !== 1'b0 || ex_epc !== 32'h18 || nested_err !== 1'b1) begin fails++; $display("FAIL nest_after got ds=%0b epc=%h err=%0b exp 0/18/1", ex_ds, ex_epc, nested_err); end
        drive(0, 32'h0, 0, 0, 0, 0, 1);
        tests++; if (nested_err !== 1'b1) begin fails++; $display("FAIL nest_sticky got err=%0b exp 1", nested_err); end
    endtask

    task automatic test_async_reset();
        drive(1, 32'h300, 0, 0, 1, 0, 0);
        tests++; if (ex_pc !== 32'h300 || nested_err !== 1'b1) begin fails++; $display("FAIL pre_rst got pc=%h err=%0b exp 300/1", ex_pc, nested_err); end
        #2 rst = 1'b1;
        #1;
        tests++; if (ex_valid !== 1'b0 || ex_pc !== '0 || ex_ds !== 1'b0 || ex_bpc !== '0) begin fails++; $display("FAIL arst_regs got v=%0b pc=%h ds=%0b bpc=%h exp all 0", ex_valid, ex_pc, ex_ds, ex_bpc); end
        tests++; if (ex_epc !== '0 || ex_bd !== 1'b0 || nested_err !== 1'b0) begin fails++; $display("FAIL arst_outs got epc=%h bd=%0b err=%0b exp all 0", ex_epc, ex_bd, nested_err); end
        @(negedge clk);
        rst = 1'b0;
        drive(1, 32'h304, 0, 0, 0, 0, 0);
        tests++; if (ex_ds !== 1'b0 || ex_pc !== 32'h304) begin fails++; $display("FAIL arst_cancel got ds=%0b pc=%h exp 0/304", ex_ds, ex_pc); end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        rst          = 1'b1;
        id_valid     = 1'b0;
        id_pc        = '0;
        id_is_jmp    = 1'b0;
        id_is_jr     = 1'b0;
        id_is_branch = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_slot();
        test_bubbles_stalls();
        test_flush_cancel();
        test_nested();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
